// File: rtl/jam_pkg.sv
// Shared constants and types for the job-assignment cost-table arbiter.
package jam_pkg;

    localparam int NJOB          = 8;
    localparam int DEF_NREQ      = 2;
    localparam int DEF_IDX_W     = $clog2(NJOB);
    localparam int DEF_COST_W    = 7;
    localparam int DEF_MAX_BURST = 8;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        REL
    } arb_state_t;

    // Requester index reached by stepping 'off' places up from 'base', wrapping at n.
    function automatic int rr_index(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/cost_rom_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick
    import jam_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int TAG_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [TAG_W-1:0] ptr,
    output logic [NREQ-1:0]  choice,
    output logic [TAG_W-1:0] idx,
    output logic             any
);

    // Scan the request vector starting at ptr; the first hit wins.
    always_comb begin
        choice = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[rr_index(int'(ptr), i, NREQ)]) begin
                any = 1'b1;
                choice[rr_index(int'(ptr), i, NREQ)] = 1'b1;
                idx = TAG_W'(rr_index(int'(ptr), i, NREQ));
            end
        end
    end

endmodule

// File: rtl/cost_rom_arb.sv
// Burst-granular round-robin arbiter sharing one cost ROM between search engines.
// A granted engine streams (W,J) lookups; each returns a tagged cost two edges later.
module cost_rom_arb
    import jam_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int COST_W    = DEF_COST_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*IDX_W-1:0] req_w,
    input  logic [NREQ*IDX_W-1:0] req_j,
    output logic [NREQ-1:0]       gnt,
    output logic [IDX_W-1:0]      rom_W,
    output logic [IDX_W-1:0]      rom_J,
    input  logic [COST_W-1:0]     rom_Cost,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [COST_W-1:0]     rsp_cost,
    output logic                  busy
);

    localparam int TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = IDX_W + 1;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [TAG_W-1:0]  owner;
    logic [TAG_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  beat_cnt;
    logic [NREQ-1:0]   pick_oh;
    logic [TAG_W-1:0]  pick_idx;
    logic              pick_any;
    logic              grab;
    logic              beat;
    logic              rel;
    logic              vld_p1;
    logic [TAG_W-1:0]  tag_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (int'(c) >= MAX_BURST) return c;
        return c + CNT_W'(1);
    endfunction

    function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] o);
        if (int'(o) >= NREQ - 1) return '0;
        return o + TAG_W'(1);
    endfunction

    function automatic logic [NREQ-1:0] tag_onehot(input logic [TAG_W-1:0] t);
        logic [NREQ-1:0] v;
        v    = '0;
        v[t] = 1'b1;
        return v;
    endfunction

    rr_pick #(
        .NREQ (NREQ),
        .TAG_W(TAG_W)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .choice(pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus grab/beat/release strobes. REL arbitrates on its exit edge so
    // that back-to-back grants are separated by exactly one gnt=0 cycle.
    always_comb begin
        state_nxt = state;
        grab      = 1'b0;
        beat      = 1'b0;
        rel       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grab      = 1'b1;
                    state_nxt = OWN;
                end
            end
            OWN: begin
                if (req[owner] && gnt[owner]) begin
                    beat = 1'b1;
                    if (req_last[owner] || beat_cnt == CNT_W'(MAX_BURST - 1)) rel = 1'b1;
                end else begin
                    rel = 1'b1;
                end
                if (rel) state_nxt = REL;
            end
            REL: begin
                if (pick_any) begin
                    grab      = 1'b1;
                    state_nxt = OWN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, owner, round-robin pointer and beat counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt      <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (grab) begin
                gnt      <= pick_oh;
                owner    <= pick_idx;
                beat_cnt <= '0;
            end else if (rel) begin
                gnt    <= '0;
                rr_ptr <= next_ptr(owner);
            end
            if (beat) beat_cnt <= sat_inc(beat_cnt);
        end
    end

    // Stage 1: accepted beat drives the ROM address and carries its owner tag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rom_W  <= '0;
            rom_J  <= '0;
            vld_p1 <= 1'b0;
            tag_p1 <= '0;
        end else begin
            vld_p1 <= beat;
            if (beat) begin
                rom_W  <= req_w[int'(owner)*IDX_W +: IDX_W];
                rom_J  <= req_j[int'(owner)*IDX_W +: IDX_W];
                tag_p1 <= owner;
            end
        end
    end

    // Stage 2: capture ROM data and strobe the tagged response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid <= '0;
            rsp_cost  <= '0;
        end else begin
            rsp_valid <= vld_p1 ? tag_onehot(tag_p1) : '0;
            if (vld_p1) rsp_cost <= rom_Cost;
        end
    end

    assign busy = (state != IDLE) | vld_p1 | (|rsp_valid);

endmodule

// File: tb/tb_cost_rom_arb.sv
// Scoreboard bench for cost_rom_arb: per-requester beat programs, ROM model Cost=8*W+J.
module tb_cost_rom_arb;

    localparam int NREQ = 2, IDX_W = 3, COST_W = 7, MAX_BURST = 8;

    typedef struct { logic [2:0] w; logic [2:0] j; bit last; bit gap; } beat_t;
    typedef struct { int tag; int cost; int due; } exp_t;
    typedef struct { int idx; int start; int len; } grant_t;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       req_last = '0;
    logic [NREQ*IDX_W-1:0] req_w = '0;
    logic [NREQ*IDX_W-1:0] req_j = '0;
    logic [NREQ-1:0]       gnt;
    logic [IDX_W-1:0]      rom_W;
    logic [IDX_W-1:0]      rom_J;
    logic [COST_W-1:0]     rom_Cost;
    logic [NREQ-1:0]       rsp_valid;
    logic [COST_W-1:0]     rsp_cost;
    logic                  busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    beat_t  prog [NREQ][$];
    exp_t   sb[$];
    grant_t glog[$];
    int     eg_idx[$];
    int     eg_len[$];
    bit     acc_prev [NREQ];
    int     rise_cyc [NREQ];
    int     n_acc    [NREQ];
    logic [NREQ-1:0] gnt_prev = '0;

    cost_rom_arb #(
        .NREQ(NREQ), .IDX_W(IDX_W), .COST_W(COST_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_last(req_last), .req_w(req_w), .req_j(req_j),
        .gnt(gnt), .rom_W(rom_W), .rom_J(rom_J), .rom_Cost(rom_Cost),
        .rsp_valid(rsp_valid), .rsp_cost(rsp_cost), .busy(busy)
    );

    assign rom_Cost = COST_W'(8 * int'(rom_W) + int'(rom_J));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic beat_t mk(input int w, input int j, input bit last, input bit gap);
        beat_t b;
        b.w = 3'(w); b.j = 3'(j); b.last = last; b.gap = gap;
        return b;
    endfunction

    function automatic int gidx(input logic [NREQ-1:0] g);
        int k = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) k = i;
        return k;
    endfunction

    // One clock: check responses at the negedge, then present the next beats and
    // record which of them the current grant will accept at the coming posedge.
    task automatic step();
        exp_t e;
        @(negedge CLK);
        cyc++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", int'(rsp_valid), 1 << e.tag);
            chk("rsp_cost", int'(rsp_cost), e.cost);
        end else begin
            chk("rsp_quiet", int'(rsp_valid), 0);
        end
        if (gnt != '0 || sb.size() > 0) chk("busy_on", int'(busy), 1);
        chk("gnt_onehot", ($countones(gnt) <= 1) ? 1 : 0, 1);
        if (gnt != '0) begin
            if (gnt != gnt_prev || glog.size() == 0)
                glog.push_back('{idx: gidx(gnt), start: cyc, len: 1});
            else
                glog[glog.size()-1].len++;
        end
        gnt_prev = gnt;
        for (int r = 0; r < NREQ; r++) begin
            if (prog[r].size() > 0 && (prog[r][0].gap || acc_prev[r])) void'(prog[r].pop_front());
            if (prog[r].size() > 0 && !prog[r][0].gap) begin
                if (!req[r]) rise_cyc[r] = cyc;
                req[r] = 1'b1;
                req_w[r*IDX_W +: IDX_W] = prog[r][0].w;
                req_j[r*IDX_W +: IDX_W] = prog[r][0].j;
                req_last[r] = prog[r][0].last;
            end else begin
                req[r] = 1'b0;
                req_w[r*IDX_W +: IDX_W] = 3'($urandom);
                req_j[r*IDX_W +: IDX_W] = 3'($urandom);
                req_last[r] = 1'($urandom);
            end
            acc_prev[r] = req[r] && gnt[r];
            if (acc_prev[r]) begin
                sb.push_back('{tag: r, cost: 8*int'(prog[r][0].w) + int'(prog[r][0].j), due: cyc + 2});
                n_acc[r]++;
            end
        end
    endtask

    function automatic bit all_idle();
        bit idle = (sb.size() == 0) && (gnt == '0);
        for (int r = 0; r < NREQ; r++) if (prog[r].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic run_idle(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!all_idle() && n < budget);
        chk("idle_reached", int'(all_idle()), 1);
        step();
        step();
        chk("busy_end", int'(busy), 0);
    endtask

    task automatic check_grants();
        chk("n_grants", glog.size(), eg_idx.size());
        for (int i = 0; i < eg_idx.size() && i < glog.size(); i++) begin
            chk("gnt_idx", glog[i].idx, eg_idx[i]);
            chk("gnt_len", glog[i].len, eg_len[i]);
            if (i > 0) chk("gnt_gap", glog[i].start - (glog[i-1].start + glog[i-1].len), 1);
        end
        glog.delete();
        eg_idx.delete();
        eg_len.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_rom_W", int'(rom_W), 0);
        chk("rst_rom_J", int'(rom_J), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_cost", int'(rsp_cost), 0);
        chk("rst_busy", int'(busy), 0);
    endtask

    initial begin
        for (int r = 0; r < NREQ; r++) begin
            acc_prev[r] = 1'b0; rise_cyc[r] = 0; n_acc[r] = 0;
        end
        repeat (3) step();
        check_reset_outputs();

        // Both requesters high from reset, 3-beat bursts each.
        for (int k = 0; k < 3; k++) begin
            prog[0].push_back(mk(k + 1, k, k == 2, 0));
            prog[1].push_back(mk(5 - k, 6 - k, k == 2, 0));
        end
        step();
        RST = 1'b0;
        run_idle(100);
        if (glog.size() > 0) chk("s2_gnt_lat", glog[0].start, rise_cyc[0] + 1);
        eg_idx = '{0, 1}; eg_len = '{3, 3};
        check_grants();

        // Continuous 1-beat bursts from both: strict alternation.
        for (int k = 0; k < 5; k++) begin
            prog[0].push_back(mk($urandom_range(7), $urandom_range(7), 1, 0));
            prog[1].push_back(mk($urandom_range(7), $urandom_range(7), 1, 0));
        end
        run_idle(200);
        for (int k = 0; k < 10; k++) begin
            eg_idx.push_back(k % 2);
            eg_len.push_back(1);
        end
        check_grants();

        // Single requester, 8 beats W=0..7, J=7-W, last on beat 8.
        for (int k = 0; k < 8; k++) prog[0].push_back(mk(k, 7 - k, k == 7, 0));
        run_idle(100);
        if (glog.size() > 0) chk("s1_gnt_lat", glog[0].start, rise_cyc[0] + 1);
        eg_idx = '{0}; eg_len = '{8};
        check_grants();

        // 12 beats without last while requester 1 waits: forced release after 8.
        for (int k = 0; k < 12; k++) prog[0].push_back(mk(k % 8, (k * 3) % 8, 0, 0));
        prog[1].push_back(mk(0, 0, 0, 1));
        prog[1].push_back(mk(0, 0, 0, 1));
        for (int k = 0; k < 3; k++) prog[1].push_back(mk(7 - k, k + 2, k == 2, 0));
        run_idle(200);
        eg_idx = '{0, 1, 0}; eg_len = '{8, 3, 5};
        check_grants();

        // Abandon after 3 beats: grant drops after the req=0 cycle, 3 responses only.
        n_acc[0] = 0;
        for (int k = 0; k < 3; k++) prog[0].push_back(mk(k + 4, k + 1, 0, 0));
        run_idle(100);
        chk("s5_beats", n_acc[0], 3);
        eg_idx = '{0}; eg_len = '{4};
        check_grants();

        // Reset between beats 4 and 5 with responses in flight.
        n_acc[0] = 0;
        for (int k = 0; k < 8; k++) prog[0].push_back(mk(k, k, k == 7, 0));
        for (int n = 0; n < 50 && n_acc[0] < 4; n++) step();
        chk("s6_beats", n_acc[0], 4);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 check_reset_outputs();
        sb.delete();
        glog.delete();
        for (int r = 0; r < NREQ; r++) begin
            prog[r].delete();
            acc_prev[r] = 1'b0;
        end
        gnt_prev = '0;
        step();
        step();
        RST = 1'b0;
        prog[0].push_back(mk(2, 3, 1, 0));
        prog[1].push_back(mk(6, 1, 1, 0));
        run_idle(100);
        eg_idx = '{0, 1}; eg_len = '{1, 1};
        check_grants();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
